reg_file_sb: RTL and testbench

Integer register file with a write-back scoreboard; it is the receiving end of the write-back stage's register-write interface. It holds 32 x 32-bit general registers, accepts one write per cycle from WB, and serves two combinational read ports to the decode stage. A write-through bypass covers a same-cycle WB write. A per-register busy scoreboard, set by decode at issue and cleared by the WB write, lets hazard logic stall on pending producers.

---
 rtl/reg_file_sb.sv | 133 +++++++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x XLEN integer register file with a write-back busy scoreboard.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   reg_write_i, rd_addr_i,
//   write_data_i            : write-back register write (one per cycle)
//   rs1/rs2_addr_i          : read addresses from decode
//   rs1/rs2_data_o          : combinational read data (optional write-through bypass)
//   busy_set_i, busy_rd_i   : decode marks a destination register pending at issue
//   flush_i                 : clears every pending mark
//   rs1/rs2_busy_o          : pending-producer flags for the read addresses
//   busy_vec_o              : raw scoreboard bits, bit n = register n
module reg_file_sb #(
    parameter int unsigned XLEN      = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            reg_write_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            busy_set_i,
    input  logic [4:0]      busy_rd_i,
    input  logic            flush_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic [31:0]     busy_vec_o
);

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    // x0 is hard-wired zero and has no storage
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic             wr_en;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [XLEN-1:0]  rs1_store;
    logic [XLEN-1:0]  rs2_store;

    // Writes to x0 are dropped
    assign wr_en = reg_write_i && (rd_addr_i != '0);

    // Same-cycle WB write to a read address (only meaningful with bypass enabled)
    assign rs1_hit = BYPASS_EN && reg_write_i && (rd_addr_i == rs1_addr_i);
    assign rs2_hit = BYPASS_EN && reg_write_i && (rd_addr_i == rs2_addr_i);

    // Register storage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 1; n < NREGS; n++) begin
                regs_q[n] <= '0;
            end
        end else begin
            for (int n = 1; n < NREGS; n++) begin
                if (wr_en && (rd_addr_i == AW'(n))) begin
                    regs_q[n] <= write_data_i;
                end
            end
        end
    end

    // Scoreboard next state: set beats clear (younger producer), flush beats all
    always_comb begin
        busy_d = busy_q;
        for (int n = 1; n < NREGS; n++) begin
            if (busy_set_i && (busy_rd_i == AW'(n))) begin
                busy_d[n] = 1'b1;
            end else if (reg_write_i && (rd_addr_i == AW'(n))) begin
                busy_d[n] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Stored-value lookup per read port; address 0 falls through to zero
    always_comb begin
        rs1_store = '0;
        rs2_store = '0;
        for (int n = 1; n < NREGS; n++) begin
            if (rs1_addr_i == AW'(n)) begin
                rs1_store = regs_q[n];
            end
            if (rs2_addr_i == AW'(n)) begin
                rs2_store = regs_q[n];
            end
        end
    end

    // Read data with write-through bypass
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (rs1_addr_i != '0) begin
            rs1_data_o = rs1_hit ? write_data_i : rs1_store;
        end
        if (rs2_addr_i != '0) begin
            rs2_data_o = rs2_hit ? write_data_i : rs2_store;
        end
    end

    // Busy flags: a bypassed write already supplies the data, so no stall
    always_comb begin
        rs1_busy_o = 1'b0;
        rs2_busy_o = 1'b0;
        if ((rs1_addr_i != '0) && !rs1_hit) begin
            rs1_busy_o = busy_q[rs1_addr_i];
        end
        if ((rs2_addr_i != '0) && !rs2_hit) begin
            rs2_busy_o = busy_q[rs2_addr_i];
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypass-enabled and one bypass-disabled
// instance driven by the same stimulus.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_set;
    logic [4:0]  busy_rd;
    logic        flush;

    logic [31:0] rs1_data,   rs2_data;
    logic        rs1_busy,   rs2_busy;
    logic [31:0] busy_vec;
    logic [31:0] nb_rs1_data, nb_rs2_data;
    logic        nb_rs1_busy, nb_rs2_busy;
    logic [31:0] nb_busy_vec;

    int checks   = 0;
    int failures = 0;

    reg_file_sb #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .reg_write_i(reg_write), .rd_addr_i(rd_addr), .write_data_i(write_data),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .busy_set_i(busy_set), .busy_rd_i(busy_rd), .flush_i(flush),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .busy_vec_o(busy_vec)
    );

    reg_file_sb #(.XLEN(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk_i(clk), .rst_n_i(rst_n),
        .reg_write_i(reg_write), .rd_addr_i(rd_addr), .write_data_i(write_data),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(nb_rs1_data), .rs2_data_o(nb_rs2_data),
        .busy_set_i(busy_set), .busy_rd_i(busy_rd), .flush_i(flush),
        .rs1_busy_o(nb_rs1_busy), .rs2_busy_o(nb_rs2_busy), .busy_vec_o(nb_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        rd_addr    = '0;
        write_data = '0;
        busy_set   = 1'b0;
        busy_rd    = '0;
        flush      = 1'b0;
    endtask

    initial begin
        idle();
        rst_n    = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        #3;
        chk("reset_rs1_data", rs1_data, 32'h0);
        chk("reset_rs2_data", rs2_data, 32'h0);
        chk("reset_rs1_busy", 32'(rs1_busy), 32'h0);
        chk("reset_rs2_busy", 32'(rs2_busy), 32'h0);
        chk("reset_busy_vec", busy_vec, 32'h0);
        #9;
        rst_n = 1'b1;

        // Write x7, read next cycle
        step(); idle();
        reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'hDEADBEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        step(); idle();
        rs1_addr = 5'd7;
        #1;
        chk("wr_x7_rs1", rs1_data, 32'hDEADBEEF);
        chk("wr_x7_rs1_nb", nb_rs1_data, 32'hDEADBEEF);

        // Write to x0 is discarded, even on the bypass path
        step(); idle();
        reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'h1234;
        rs1_addr = 5'd0;
        #1;
        chk("x0_bypass", rs1_data, 32'h0);
        step(); idle();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        chk("x0_rs1", rs1_data, 32'h0);
        chk("x0_rs2", rs2_data, 32'h0);

        // Same-cycle bypass on both ports; no-bypass instance returns old value
        step(); idle();
        reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'hA5A5A5A5;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        chk("byp_rs1", rs1_data, 32'hA5A5A5A5);
        chk("byp_rs2", rs2_data, 32'hA5A5A5A5);
        chk("nobyp_rs1", nb_rs1_data, 32'h0);
        chk("nobyp_rs2", nb_rs2_data, 32'h0);
        step(); idle();
        rs1_addr = 5'd3;
        #1;
        chk("nobyp_rs1_after", nb_rs1_data, 32'hA5A5A5A5);

        // Scoreboard set on x10 becomes visible next cycle
        step(); idle();
        busy_set = 1'b1; busy_rd = 5'd10; rs1_addr = 5'd10;
        #1;
        chk("sb_set_same_cycle", 32'(rs1_busy), 32'h0);
        step(); idle();
        rs1_addr = 5'd10;
        #1;
        chk("sb_set_rs1_busy", 32'(rs1_busy), 32'h1);
        chk("sb_set_vec", busy_vec, 32'h0000_0400);
        chk("sb_set_rs1_busy_nb", 32'(nb_rs1_busy), 32'h1);

        // WB write to x10 masks busy in the same cycle (bypass only)
        step(); idle();
        reg_write = 1'b1; rd_addr = 5'd10; write_data = 32'h55;
        rs1_addr = 5'd10;
        #1;
        chk("sb_clr_mask", 32'(rs1_busy), 32'h0);
        chk("sb_clr_nomask_nb", 32'(nb_rs1_busy), 32'h1);
        chk("sb_clr_data", rs1_data, 32'h55);
        chk("sb_clr_vec_still", busy_vec, 32'h0000_0400);
        step(); idle();
        rs1_addr = 5'd10;
        #1;
        chk("sb_clr_vec", busy_vec, 32'h0);
        chk("sb_clr_rs1_busy", 32'(rs1_busy), 32'h0);

        // Set and clear of x12 in the same cycle: set wins, data commits
        step(); idle();
        busy_set = 1'b1; busy_rd = 5'd12;
        reg_write = 1'b1; rd_addr = 5'd12; write_data = 32'h12121212;
        step(); idle();
        rs1_addr = 5'd12; rs2_addr = 5'd12;
        #1;
        chk("coll_vec", busy_vec, 32'h0000_1000);
        chk("coll_rs1_data", rs1_data, 32'h12121212);
        chk("coll_rs2_busy", 32'(rs2_busy), 32'h1);

        // Set on x0 is ignored
        step(); idle();
        busy_set = 1'b1; busy_rd = 5'd0;
        step(); idle();
        #1;
        chk("set_x0_ignored", busy_vec, 32'h0000_1000);

        // Flush overrides a same-cycle set; the same-cycle write still commits
        busy_set = 1'b1; busy_rd = 5'd4;
        step(); idle();
        busy_set = 1'b1; busy_rd = 5'd9;
        step(); idle();
        #1;
        chk("pre_flush_vec", busy_vec, 32'h0000_1210);
        flush = 1'b1; busy_set = 1'b1; busy_rd = 5'd6;
        reg_write = 1'b1; rd_addr = 5'd20; write_data = 32'hCAFEF00D;
        step(); idle();
        rs2_addr = 5'd20;
        #1;
        chk("flush_vec", busy_vec, 32'h0);
        chk("flush_write", rs2_data, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a write
        busy_set = 1'b1; busy_rd = 5'd5;
        step(); idle();
        reg_write = 1'b1; rd_addr = 5'd21; write_data = 32'h0BADF00D;
        rs1_addr = 5'd7; rs2_addr = 5'd3;
        #1;
        chk("pre_rst_vec", busy_vec, 32'h0000_0020);
        chk("pre_rst_rs1", rs1_data, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vec", busy_vec, 32'h0);
        chk("arst_rs1", rs1_data, 32'h0);
        chk("arst_rs2", rs2_data, 32'h0);
        step(); idle();
        rst_n = 1'b1;
        rs1_addr = 5'd21; rs2_addr = 5'd20;
        #1;
        chk("arst_lost_write", rs1_data, 32'h0);
        chk("arst_x20", rs2_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
